sti_rx: RTL and testbench
=========================

# sti_rx

Serial receiver for the serial-transmission output port. It consumes the one-bit `so_data`/`so_valid` stream produced by the parallel-to-serial stage and reassembles each burst into a right-aligned word of 8, 16, 24 or 32 bits. In parallel it emits a byte stream with running addresses, which lets the bench check the serial link independently of the pixel memory path. Words are framed purely by `si_valid`: one burst equals one word.

## Interface

- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `si_data`  in  1  serial bit, connected to the transmitter `so_data`.
- `si_valid`  in  1  bit-valid, connected to the transmitter `so_valid`.
- `rx_msb`  in  1  1: first received bit is the word MSB; 0: first received bit is bit 0. Latched on the first bit of each word.
- `word_out`  out  32  reassembled word, right-aligned, zero-extended.
- `word_len`  out  6  bit count of the word, saturated at 32.
- `word_valid`  out  1  one-cycle pulse marking `word_out`/`word_len`/`word_err` valid.
- `word_err`  out  1  framing error; valid only with `word_valid`.
- `byte_out`  out  8  byte assembled in arrival order, first bit in bit 7.
- `byte_valid`  out  1  one-cycle pulse per completed byte.
- `byte_addr`  out  8  index of the current byte; increments after each byte and wraps 255→0.
- `word_count`  out  16  number of completed words; wraps.
- `checksum`  out  8  running byte sum (see Configuration).

## Operation

- State: shift register `sh[31:0]`, bit counter `cnt[5:0]` (saturates at 33), byte shifter `bsh[7:0]`, byte bit count `bcnt[2:0]`, and latched `msb_q`.
- IDLE (`cnt==0`): no action while `si_valid=0`. On the first `si_valid=1`, latch `msb_q<=rx_msb`.
- RECEIVE (`si_valid=1`):
  - If `cnt<32`: when msb mode is active (`rx_msb` on the first bit, `msb_q` after that), `sh<={sh[30:0],si_data}`; otherwise `sh[cnt]<=si_data`.
  - Bits beyond 32 are not stored. Only the first 32 bits are kept, in both modes.
  - `cnt<=min(cnt+1,33)`.
- CLOSE (`si_valid=0` and `cnt!=0`):
  - `word_out<=sh`, `word_len<=min(cnt,32)`.
  - `word_err<=1` when `cnt` is not in {8,16,24,32}. This covers both the overflow case (33) and a trailing partial byte.
  - `word_valid<=1`, `word_count++`, then clear `sh`, `cnt`, `bsh` and `bcnt`.
- Byte path (every `si_valid=1` cycle):
  - `bsh<={bsh[6:0],si_data}`, `bcnt++`.
  - When `bcnt==7`: `byte_out<={bsh[6:0],si_data}`, `byte_valid<=1`, `byte_addr` increments after the byte (the first byte after reset reports addr 0).
  - The byte path continues past 32 bits.
  - A partial byte at CLOSE is discarded with no `byte_valid`.
- `rx_msb` changes in mid-word have no effect.

## Timing

- Reset values: `word_out=0`, `word_len=0`, `word_valid=0`, `word_err=0`, `byte_out=0`, `byte_valid=0`, `byte_addr=0`, `word_count=0`, `checksum=0`; all internal state is cleared.
- `word_valid` goes high in the cycle after the edge that first samples `si_valid=0` following a burst. Latency is 1 clock from the end of the burst, and the pulse lasts 1 cycle.
- `byte_valid` goes high in the cycle after the edge that samples the 8th bit of a byte.
- `word_valid` and `byte_valid` are never asserted together, because a byte completes on a valid cycle and a word closes on an invalid cycle.
- Back-to-back words: one `si_valid=0` cycle between bursts is sufficient. A new burst may start in the cycle immediately after CLOSE.
- Reset during a burst: the partial word is dropped and no `word_valid` is produced.
- The block has no backpressure. Downstream logic must accept the pulses when they occur.

## Configuration

- `STI_RX_CHECKSUM_EN` defined:
  - `checksum` is the modulo-256 sum of all emitted bytes.
  - It updates on the same edge that raises `byte_valid`, so it already includes the current byte.
  - It is cleared only by reset.
- Not defined: `checksum` is driven constant 8'h00 and no adder is synthesized.

## Test plan

- MSB-first, 8 bits 1,0,1,0,0,1,0,1 → `word_out=0x000000A5`, `word_len=8`, `word_err=0`; `byte_out=0xA5` at `byte_addr=0`.
- `rx_msb=0`, 16-bit 0x1234 sent LSB-first → `word_out=0x00001234`, `word_len=16`; bytes 0x2C (addr 0) then 0x48 (addr 1).
- 40-bit burst, MSB-first, all 1s → `word_len=32`, `word_err=1`, `word_out=0xFFFFFFFF`; five bytes of 0xFF.
- 12-bit burst → `word_err=1`, `word_len=12`; one `byte_valid`; no second byte.
- Reset asserted after 5 bits of a 16-bit burst, followed by a clean 8-bit 0x3C → only one `word_valid`, with `word_out=0x3C`, `word_count=1`, `byte_addr` of that byte 0.
- With `STI_RX_CHECKSUM_EN`: bytes 0xF0, 0x20 → `checksum=0x10`. Without the macro, `checksum` stays 0x00.

Source files
------------

// File: rtl/sti_rx.sv
// Serial receiver: reassembles si_valid-framed bursts into right-aligned words plus an addressed byte stream.
// Optional running byte checksum is enabled by defining STI_RX_CHECKSUM_EN.
module sti_rx (
  input  logic        clk,
  input  logic        reset,
  input  logic        si_data,
  input  logic        si_valid,
  input  logic        rx_msb,
  output logic [31:0] word_out,
  output logic [5:0]  word_len,
  output logic        word_valid,
  output logic        word_err,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [7:0]  byte_addr,
  output logic [15:0] word_count,
  output logic [7:0]  checksum
);

  logic [31:0] sh;
  logic [5:0]  cnt;
  logic [7:0]  bsh;
  logic [2:0]  bcnt;
  logic        msb_q;
  logic        msb_mode;
  logic [7:0]  byte_next;
  logic        byte_done;

  // The first bit of a word uses the live rx_msb; later bits use the latched copy.
  assign msb_mode  = (cnt == 6'd0) ? rx_msb : msb_q;
  assign byte_next = {bsh[6:0], si_data};
  assign byte_done = si_valid && (bcnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      sh         <= '0;
      cnt        <= '0;
      bsh        <= '0;
      bcnt       <= '0;
      msb_q      <= 1'b0;
      word_out   <= '0;
      word_len   <= '0;
      word_valid <= 1'b0;
      word_err   <= 1'b0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      byte_addr  <= '0;
      word_count <= '0;
    end else begin
      word_valid <= 1'b0;
      byte_valid <= 1'b0;
      // The address moves on only after the pulse has presented the current index.
      if (byte_valid)
        byte_addr <= byte_addr + 8'd1;
      if (si_valid) begin
        if (cnt == 6'd0)
          msb_q <= rx_msb;
        if (cnt < 6'd32) begin
          if (msb_mode)
            sh <= {sh[30:0], si_data};
          else
            sh[cnt[4:0]] <= si_data;
        end
        if (cnt != 6'd33)
          cnt <= cnt + 6'd1;
        bsh  <= byte_next;
        bcnt <= bcnt + 3'd1;
        if (byte_done) begin
          byte_out   <= byte_next;
          byte_valid <= 1'b1;
        end
      end else if (cnt != 6'd0) begin
        word_out   <= sh;
        word_len   <= (cnt > 6'd32) ? 6'd32 : cnt;
        word_err   <= !((cnt == 6'd8) || (cnt == 6'd16) || (cnt == 6'd24) || (cnt == 6'd32));
        word_valid <= 1'b1;
        word_count <= word_count + 16'd1;
        sh         <= '0;
        cnt        <= '0;
        bsh        <= '0;
        bcnt       <= '0;
      end
    end
  end

`ifdef STI_RX_CHECKSUM_EN
  logic [7:0] sum_q;

  // Sum includes the byte being emitted on the same edge.
  always_ff @(posedge clk) begin
    if (reset)
      sum_q <= '0;
    else if (byte_done)
      sum_q <= sum_q + byte_next;
  end

  assign checksum = sum_q;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_sti_rx.sv
// Scoreboard bench for sti_rx: expected words/bytes are queued as bursts are driven and popped on the output pulses.
module tb_sti_rx;

  logic        clk;
  logic        reset;
  logic        si_data;
  logic        si_valid;
  logic        rx_msb;
  logic [31:0] word_out;
  logic [5:0]  word_len;
  logic        word_valid;
  logic        word_err;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [7:0]  byte_addr;
  logic [15:0] word_count;
  logic [7:0]  checksum;

  sti_rx dut (
    .clk        (clk),
    .reset      (reset),
    .si_data    (si_data),
    .si_valid   (si_valid),
    .rx_msb     (rx_msb),
    .word_out   (word_out),
    .word_len   (word_len),
    .word_valid (word_valid),
    .word_err   (word_err),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_addr  (byte_addr),
    .word_count (word_count),
    .checksum   (checksum)
  );

  typedef struct {
    logic [31:0] word;
    logic [5:0]  len;
    logic        err;
    logic [15:0] count;
  } word_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] addr;
    logic [7:0] cksum;
  } byte_t;

  word_t wq[$];
  byte_t bq[$];

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_addr;
  logic [15:0] exp_count;
  logic [7:0]  exp_sum;

  logic [31:0] obs_word;
  logic [5:0]  obs_len;
  logic        obs_err;
  logic [15:0] obs_count;
  logic [7:0]  last_byte;
  logic [7:0]  last_addr;
  int          words_seen = 0;
  int          bytes_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] mkSeq(input logic [63:0] v, input int n, input logic msb_first);
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < n; k++)
      s[k] = msb_first ? v[n-1-k] : v[k];
    return s;
  endfunction

  // seq[k] is the k-th bit on the wire; expectations are queued before driving.
  task automatic applyStimulus(input logic [63:0] seq, input int n, input logic msb);
    logic [31:0] w;
    logic [7:0]  b;
    int          bc;
    word_t       ew;
    byte_t       eb;
    w  = '0;
    b  = '0;
    bc = 0;
    for (int k = 0; k < n; k++) begin
      if (k < 32) begin
        if (msb)
          w = {w[30:0], seq[k]};
        else
          w[k] = seq[k];
      end
      b = {b[6:0], seq[k]};
      bc++;
      if (bc == 8) begin
        exp_sum  = exp_sum + b;
        eb.data  = b;
        eb.addr  = exp_addr;
`ifdef STI_RX_CHECKSUM_EN
        eb.cksum = exp_sum;
`else
        eb.cksum = 8'h00;
`endif
        bq.push_back(eb);
        exp_addr = exp_addr + 8'd1;
        bc = 0;
      end
    end
    exp_count = exp_count + 16'd1;
    ew.word  = w;
    ew.len   = (n > 32) ? 6'd32 : 6'(n);
    ew.err   = !((n == 8) || (n == 16) || (n == 24) || (n == 32));
    ew.count = exp_count;
    wq.push_back(ew);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      si_valid = 1'b1;
      si_data  = seq[k];
      rx_msb   = (k == 0) ? msb : ~msb;
    end
    @(posedge clk);
    #1;
    si_valid = 1'b0;
    si_data  = 1'b0;
  endtask

  task automatic doReset();
    reset    = 1'b1;
    si_valid = 1'b0;
    si_data  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    exp_addr  = '0;
    exp_count = '0;
    exp_sum   = '0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    word_t w;
    byte_t b;
    if (!reset) begin
      if (word_valid || byte_valid)
        checkOutput("pulse_overlap", 32'(word_valid & byte_valid), 32'd0);
      if (word_valid) begin
        words_seen++;
        obs_word  = word_out;
        obs_len   = word_len;
        obs_err   = word_err;
        obs_count = word_count;
        if (wq.size() == 0) begin
          checkOutput("spurious_word", 32'(word_valid), 32'd0);
        end else begin
          w = wq.pop_front();
          checkOutput("word_out", word_out, w.word);
          checkOutput("word_len", 32'(word_len), 32'(w.len));
          checkOutput("word_err", 32'(word_err), 32'(w.err));
          checkOutput("word_count", 32'(word_count), 32'(w.count));
        end
      end
      if (byte_valid) begin
        bytes_seen++;
        last_byte = byte_out;
        last_addr = byte_addr;
        if (bq.size() == 0) begin
          checkOutput("spurious_byte", 32'(byte_valid), 32'd0);
        end else begin
          b = bq.pop_front();
          checkOutput("byte_out", 32'(byte_out), 32'(b.data));
          checkOutput("byte_addr", 32'(byte_addr), 32'(b.addr));
          checkOutput("checksum_run", 32'(checksum), 32'(b.cksum));
        end
      end
    end
  end

  initial begin
    int ws;
    int bs;
    logic [63:0] seq;
    int n;
    logic m;

    reset     = 1'b1;
    si_data   = 1'b0;
    si_valid  = 1'b0;
    rx_msb    = 1'b0;
    exp_addr  = '0;
    exp_count = '0;
    exp_sum   = '0;
    doReset();
    @(negedge clk);
    checkOutput("rst_word_out", word_out, 32'd0);
    checkOutput("rst_word_len", 32'(word_len), 32'd0);
    checkOutput("rst_word_valid", 32'(word_valid), 32'd0);
    checkOutput("rst_word_err", 32'(word_err), 32'd0);
    checkOutput("rst_byte_out", 32'(byte_out), 32'd0);
    checkOutput("rst_byte_valid", 32'(byte_valid), 32'd0);
    checkOutput("rst_byte_addr", 32'(byte_addr), 32'd0);
    checkOutput("rst_word_count", 32'(word_count), 32'd0);
    checkOutput("rst_checksum", 32'(checksum), 32'd0);

    $display("[TB] MSB-first 8-bit 0xA5");
    applyStimulus(mkSeq(64'hA5, 8, 1'b1), 8, 1'b1);
    settle();
    checkOutput("t1_word", obs_word, 32'h0000_00A5);
    checkOutput("t1_len", 32'(obs_len), 32'd8);
    checkOutput("t1_err", 32'(obs_err), 32'd0);
    checkOutput("t1_byte", 32'(last_byte), 32'hA5);
    checkOutput("t1_addr", 32'(last_addr), 32'd0);

    $display("[TB] LSB-first 16-bit 0x1234");
    doReset();
    bs = bytes_seen;
    applyStimulus(mkSeq(64'h1234, 16, 1'b0), 16, 1'b0);
    settle();
    checkOutput("t2_word", obs_word, 32'h0000_1234);
    checkOutput("t2_len", 32'(obs_len), 32'd16);
    checkOutput("t2_last_byte", 32'(last_byte), 32'h48);
    checkOutput("t2_last_addr", 32'(last_addr), 32'd1);
    checkOutput("t2_nbytes", 32'(bytes_seen - bs), 32'd2);

    $display("[TB] 40-bit all-ones overflow");
    bs = bytes_seen;
    applyStimulus(64'h0000_00FF_FFFF_FFFF, 40, 1'b1);
    settle();
    checkOutput("t3_word", obs_word, 32'hFFFF_FFFF);
    checkOutput("t3_len", 32'(obs_len), 32'd32);
    checkOutput("t3_err", 32'(obs_err), 32'd1);
    checkOutput("t3_nbytes", 32'(bytes_seen - bs), 32'd5);

    $display("[TB] 12-bit partial byte");
    bs = bytes_seen;
    applyStimulus(mkSeq(64'hABC, 12, 1'b1), 12, 1'b1);
    settle();
    checkOutput("t4_word", obs_word, 32'h0000_0ABC);
    checkOutput("t4_len", 32'(obs_len), 32'd12);
    checkOutput("t4_err", 32'(obs_err), 32'd1);
    checkOutput("t4_nbytes", 32'(bytes_seen - bs), 32'd1);
    checkOutput("t4_byte", 32'(last_byte), 32'hAB);

    $display("[TB] reset during burst");
    ws = words_seen;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      si_valid = 1'b1;
      si_data  = k[0];
      rx_msb   = 1'b1;
    end
    @(posedge clk);
    #1;
    doReset();
    applyStimulus(mkSeq(64'h3C, 8, 1'b1), 8, 1'b1);
    settle();
    checkOutput("t5_nwords", 32'(words_seen - ws), 32'd1);
    checkOutput("t5_word", obs_word, 32'h0000_003C);
    checkOutput("t5_count", 32'(obs_count), 32'd1);
    checkOutput("t5_addr", 32'(last_addr), 32'd0);

    $display("[TB] checksum bytes 0xF0 0x20");
    doReset();
    applyStimulus(mkSeq(64'hF020, 16, 1'b1), 16, 1'b1);
    settle();
`ifdef STI_RX_CHECKSUM_EN
    checkOutput("t6_checksum", 32'(checksum), 32'h10);
`else
    checkOutput("t6_checksum", 32'(checksum), 32'h00);
`endif

    $display("[TB] back-to-back and random bursts");
    applyStimulus(mkSeq(64'h5A, 8, 1'b1), 8, 1'b1);
    applyStimulus(mkSeq(64'hC3_96, 16, 1'b0), 16, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n   = $urandom_range(1, 40);
      m   = 1'($urandom_range(0, 1));
      seq = {$urandom, $urandom};
      applyStimulus(seq, n, m);
    end
    settle();

    checkOutput("words_pending", 32'(wq.size()), 32'd0);
    checkOutput("bytes_pending", 32'(bq.size()), 32'd0);
    checkOutput("final_count", 32'(word_count), 32'(exp_count));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
